hero_write_rx: RTL and testbench
================================

// Module: hero_write_rx
// PURPOSE
//  Receive-side stage for the hero write bus: consumes one test_pkg_a::hero_write_t per clock.
//  Groups beats into transactions (VALID* ... DONE) and buffers them in a FIFO.
//  Presents each beat downstream on a valid/ready interface, with a beat index, last and truncate flags.
//  The hero bus has no backpressure, so buffer overflow and protocol violations are absorbed here and flagged.
// PARAMETERS
//  DEPTH      8   FIFO entries; power of 2, >= 2
//  MAX_BEATS  16  max beats per transaction; power of 2, >= 2
// PORTS
//  clk          in   1                     clock
//  rst          in   1                     reset, asynchronous, active-high
//  i_hero       in   46                    hero_write_t {cycle_type[1:0], wdat[35:0], another_type_reference[6:0], clk_en}
//  o_vld        out  1                     head entry valid
//  i_rdy        in   1                     downstream accepts head (pop = o_vld & i_rdy)
//  o_wdat       out  HERO_WIDTH(36)        beat data
//  o_sub        out  7                     beat sub_def_t
//  o_beat_idx   out  clog2(MAX_BEATS)      beat index within its transaction, 0-based
//  o_last       out  1                     final beat of transaction
//  o_trunc      out  1                     transaction cut short here (overflow or length)
//  o_fill       out  clog2(DEPTH+1)        current FIFO occupancy
//  o_err_ovf    out  1                     sticky: overflow truncation or dropped beat
//  o_err_proto  out  1                     sticky: illegal cycle_type or over-length transaction
//  i_err_clr    in   1                     clears both sticky errors
// BEHAVIOUR
//  Reset: FIFO empty; state IDLE; beat counter 0; errors 0; all outputs 0.
//  Reset asserted mid-transaction discards buffered and in-flight beats immediately.
//  Beat qualification: beat = clk_en & cycle_type in {VALID, DONE}.
//   - clk_en=0 or IDLE: no action.
//   - clk_en=1 with cycle_type=2'd3: sets o_err_proto; beat ignored; state unchanged.
//  free = DEPTH - fill + pop, where pop is the same-cycle pop. Each push writes {wdat, sub, idx, last, trunc}.
//  FSM states:
//   IDLE:
//    - DONE: push idx0, last=1; stay IDLE.
//    - VALID, free >= 2: push idx0; go OPEN.
//    - VALID, free == 1: push last=1, trunc=1; set ovf; go DROP.
//    - Any beat, free == 0: drop the beat; set ovf; VALID goes to DROP, DONE stays IDLE.
//   OPEN:
//    - DONE: push last=1; go IDLE.
//    - VALID, normal case: push, idx+1.
//    - VALID with idx == MAX_BEATS-1: push last=1, trunc=1; set proto; go DROP.
//    - VALID with free == 1: push last=1, trunc=1; set ovf; go DROP.
//    - OPEN always has free >= 1, because each non-last push leaves one slot free.
//   DROP: discard all beats; DONE goes to IDLE. Illegal cycle_type is still flagged.
//  Beat counter: 0 in IDLE; holds the idx of the next beat; never exceeds MAX_BEATS-1.
//  Output FIFO: first-word fall-through.
//   - Beat pushed at edge N into an empty FIFO: o_vld=1 from cycle N+1.
//   - Push and pop in the same cycle are both honoured, including when full (the pop frees the slot).
//   - Read/write pointers wrap modulo DEPTH.
//   - Head fields are held stable while o_vld & !i_rdy.
//   - Data outputs are 0 when empty.
//  Errors: set has priority over i_err_clr in the same cycle.
// TESTING
//  1. i_rdy=1; VALID, VALID, DONE -> o_vld on 3 consecutive cycles starting 1 cycle later; idx 0,1,2; last only on idx2; trunc=0.
//  2. Lone DONE in IDLE with wdat=36'h123456789 -> one entry with idx0, last=1, o_wdat=36'h123456789.
//  3. i_rdy=0; 10 VALID then DONE:
//     - entries idx0-6 normal; entry idx7 has last=1, trunc=1; o_err_ovf=1; o_fill=8; remaining beats dropped.
//     - After draining, a new txn is accepted.
//  4. i_rdy=1; 20 VALID then DONE:
//     - beat idx15 has last=1, trunc=1; o_err_proto=1; beats 17-21 dropped.
//     - State is IDLE after DONE.
//  5. clk_en=0 with VALID -> no push.
//     cycle_type=3 -> o_err_proto=1, no push.
//     i_err_clr -> both errors 0 next cycle; clear coincident with a new violation -> error stays 1.
//  6. rst pulsed with fill=4 mid-txn -> o_vld=0, o_fill=0 without waiting for clk; next DONE -> single-beat txn, idx0.

Source files
------------

// File: rtl/hero_write_rx.sv
`default_nettype none
// ============================================================================
// Module      : hero_write_rx
// Description : Receive stage for the hero write bus. Qualifies one
//               hero_write_t beat per clock, groups beats into transactions
//               (VALID* ... DONE) and buffers them in a first-word
//               fall-through FIFO presented on a valid/ready interface.
//               The hero bus cannot be stalled, so overflow and protocol
//               violations are absorbed here and reported as sticky errors.
// Ports       : clk, rst (async, active-high)
//               i_hero      {cycle_type[1:0], wdat[35:0], sub[6:0], clk_en}
//               o_vld/i_rdy head entry handshake (pop = o_vld & i_rdy)
//               o_wdat, o_sub, o_beat_idx, o_last, o_trunc  head fields
//               o_fill      FIFO occupancy
//               o_err_ovf, o_err_proto  sticky errors, cleared by i_err_clr
// Revision    : 1.0  initial release
// ============================================================================
module hero_write_rx #(
    parameter int DEPTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic [45:0]                    i_hero,
    output logic                                o_vld,
    input  wire logic                           i_rdy,
    output logic [35:0]                         o_wdat,
    output logic [6:0]                          o_sub,
    output logic [$clog2(MAX_BEATS)-1:0]        o_beat_idx,
    output logic                                o_last,
    output logic                                o_trunc,
    output logic [$clog2(DEPTH+1)-1:0]          o_fill,
    output logic                                o_err_ovf,
    output logic                                o_err_proto,
    input  wire logic                           i_err_clr
);

    localparam int c_IW = $clog2(MAX_BEATS);
    localparam int c_FW = $clog2(DEPTH+1);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_EW = 36 + 7 + c_IW + 2;

    localparam logic [1:0]      c_CT_VALID = 2'd1;
    localparam logic [1:0]      c_CT_DONE  = 2'd2;
    localparam logic [1:0]      c_CT_BAD   = 2'd3;
    localparam logic [c_FW:0]   c_DEPTH_W  = (c_FW+1)'(DEPTH);
    localparam logic [c_FW:0]   c_FREE_ONE = (c_FW+1)'(1);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(MAX_BEATS-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state_q, r_state_d;
    logic [c_IW-1:0]   r_cnt_q,   r_cnt_d;
    logic [c_PW-1:0]   r_wptr_q,  r_wptr_d;
    logic [c_PW-1:0]   r_rptr_q,  r_rptr_d;
    logic [c_FW-1:0]   r_fill_q,  r_fill_d;
    logic              r_ovf_q,   r_ovf_d;
    logic              r_proto_q, r_proto_d;
    logic [c_EW-1:0]   r_mem_q [DEPTH];

    logic [1:0]        w_ct;
    logic [35:0]       w_wdat;
    logic [6:0]        w_sub;
    logic              w_en;
    logic              w_beat_v, w_beat_d, w_illegal;
    logic              w_pop;
    logic [c_FW:0]     w_free;
    logic              w_push, w_push_last, w_push_trunc;
    logic [c_IW-1:0]   w_push_idx;
    logic              w_set_ovf, w_set_proto;
    logic [c_EW-1:0]   w_entry, w_head;

    assign w_ct      = i_hero[45:44];
    assign w_wdat    = i_hero[43:8];
    assign w_sub     = i_hero[7:1];
    assign w_en      = i_hero[0];
    assign w_beat_v  = w_en & (w_ct == c_CT_VALID);
    assign w_beat_d  = w_en & (w_ct == c_CT_DONE);
    assign w_illegal = w_en & (w_ct == c_CT_BAD);

    assign o_vld  = (r_fill_q != '0);
    assign w_pop  = o_vld & i_rdy;
    // Slots available to this cycle's push, counting the same-cycle pop.
    assign w_free = c_DEPTH_W - {1'b0, r_fill_q} + {{c_FW{1'b0}}, w_pop};

    // Transaction framing FSM
    always_comb begin
        r_state_d    = r_state_q;
        r_cnt_d      = r_cnt_q;
        w_push       = 1'b0;
        w_push_idx   = '0;
        w_push_last  = 1'b0;
        w_push_trunc = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_proto  = w_illegal;
        case (r_state_q)
            S_IDLE: begin
                if (w_beat_v || w_beat_d) begin
                    if (w_free == '0) begin
                        w_set_ovf = 1'b1;
                        if (w_beat_v) r_state_d = S_DROP;
                    end else if (w_beat_d) begin
                        w_push      = 1'b1;
                        w_push_last = 1'b1;
                    end else if (w_free == c_FREE_ONE) begin
                        // Only one slot left: the transaction ends here.
                        w_push       = 1'b1;
                        w_push_last  = 1'b1;
                        w_push_trunc = 1'b1;
                        w_set_ovf    = 1'b1;
                        r_state_d    = S_DROP;
                    end else begin
                        w_push    = 1'b1;
                        r_state_d = S_OPEN;
                        r_cnt_d   = c_IW'(1);
                    end
                end
            end
            S_OPEN: begin
                // Every non-last push leaves a slot, so free >= 1 here.
                if (w_beat_d) begin
                    w_push      = 1'b1;
                    w_push_idx  = r_cnt_q;
                    w_push_last = 1'b1;
                    r_state_d   = S_IDLE;
                    r_cnt_d     = '0;
                end else if (w_beat_v) begin
                    w_push     = 1'b1;
                    w_push_idx = r_cnt_q;
                    if ((r_cnt_q == c_LAST_IDX) || (w_free == c_FREE_ONE)) begin
                        w_push_last  = 1'b1;
                        w_push_trunc = 1'b1;
                        w_set_proto  = (r_cnt_q == c_LAST_IDX);
                        w_set_ovf    = (w_free == c_FREE_ONE);
                        r_state_d    = S_DROP;
                        r_cnt_d      = '0;
                    end else begin
                        r_cnt_d = r_cnt_q + c_IW'(1);
                    end
                end
            end
            S_DROP: begin
                if (w_beat_d) r_state_d = S_IDLE;
            end
            default: begin
                r_state_d = S_IDLE;
                r_cnt_d   = '0;
            end
        endcase
    end

    // FIFO bookkeeping and sticky errors (set wins over clear)
    always_comb begin
        r_wptr_d  = r_wptr_q + (w_push ? c_PW'(1) : c_PW'(0));
        r_rptr_d  = r_rptr_q + (w_pop  ? c_PW'(1) : c_PW'(0));
        r_fill_d  = r_fill_q + c_FW'(w_push) - c_FW'(w_pop);
        r_ovf_d   = w_set_ovf   ? 1'b1 : (i_err_clr ? 1'b0 : r_ovf_q);
        r_proto_d = w_set_proto ? 1'b1 : (i_err_clr ? 1'b0 : r_proto_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_fill_q  <= '0;
            r_ovf_q   <= 1'b0;
            r_proto_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_wptr_q  <= r_wptr_d;
            r_rptr_q  <= r_rptr_d;
            r_fill_q  <= r_fill_d;
            r_ovf_q   <= r_ovf_d;
            r_proto_q <= r_proto_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted in fill.
    assign w_entry = {w_wdat, w_sub, w_push_idx, w_push_last, w_push_trunc};

    always_ff @(posedge clk) begin
        if (w_push) r_mem_q[r_wptr_q] <= w_entry;
    end

    assign w_head = o_vld ? r_mem_q[r_rptr_q] : '0;

    assign o_wdat      = w_head[c_EW-1 -: 36];
    assign o_sub       = w_head[c_IW+8 -: 7];
    assign o_beat_idx  = w_head[c_IW+1 : 2];
    assign o_last      = w_head[1];
    assign o_trunc     = w_head[0];
    assign o_fill      = r_fill_q;
    assign o_err_ovf   = r_ovf_q;
    assign o_err_proto = r_proto_q;

endmodule
`default_nettype wire

// File: tb/tb_hero_write_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hero_write_rx
// Description : Self-checking bench for hero_write_rx. A transaction-level
//               model (entry queue plus framing mode) predicts the FIFO
//               contents; a negedge process compares every output each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hero_write_rx;

    localparam int DEPTH     = 8;
    localparam int MAX_BEATS = 16;
    localparam logic [1:0] CT_IDLE  = 2'd0;
    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;
    localparam logic [1:0] CT_BAD   = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  d_ct;
    logic [35:0] d_wdat;
    logic [6:0]  d_sub;
    logic        d_en;
    logic [45:0] i_hero;
    logic        i_rdy, i_err_clr;
    logic        o_vld, o_last, o_trunc, o_err_ovf, o_err_proto;
    logic [35:0] o_wdat;
    logic [6:0]  o_sub;
    logic [3:0]  o_beat_idx;
    logic [3:0]  o_fill;

    assign i_hero = {d_ct, d_wdat, d_sub, d_en};

    hero_write_rx #(.DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst), .i_hero(i_hero),
        .o_vld(o_vld), .i_rdy(i_rdy),
        .o_wdat(o_wdat), .o_sub(o_sub), .o_beat_idx(o_beat_idx),
        .o_last(o_last), .o_trunc(o_trunc), .o_fill(o_fill),
        .o_err_ovf(o_err_ovf), .o_err_proto(o_err_proto),
        .i_err_clr(i_err_clr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [35:0] wdat;
        logic [6:0]  sub;
        logic [3:0]  idx;
        logic        last;
        logic        trunc;
    } ent_t;

    ent_t q[$];
    int   m_mode;   // 0: between transactions, 1: collecting, 2: discarding
    int   m_cnt;    // index the next accepted beat would get
    bit   m_ovf, m_proto;
    bit   chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic ent_t mk(input int idx, input bit last, input bit trunc);
        ent_t e;
        e.wdat = d_wdat; e.sub = d_sub; e.idx = 4'(idx); e.last = last; e.trunc = trunc;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_cnt = 0; m_ovf = 0; m_proto = 0;
    endtask

    // Applies the inputs present at this clock edge to the model.
    task automatic model_step();
        bit   pop, push, so, sp, done;
        int   free;
        ent_t e;
        pop  = (q.size() > 0) && i_rdy;
        free = DEPTH - q.size() + (pop ? 1 : 0);
        push = 0; so = 0; sp = 0;
        if (d_en && d_ct == CT_BAD) sp = 1;
        else if (d_en && (d_ct == CT_VALID || d_ct == CT_DONE)) begin
            done = (d_ct == CT_DONE);
            if (m_mode == 0) begin
                if (free == 0) begin
                    so = 1;
                    if (!done) m_mode = 2;
                end else if (done) begin
                    push = 1; e = mk(0, 1, 0);
                end else if (free == 1) begin
                    push = 1; e = mk(0, 1, 1); so = 1; m_mode = 2;
                end else begin
                    push = 1; e = mk(0, 0, 0); m_mode = 1; m_cnt = 1;
                end
            end else if (m_mode == 1) begin
                if (done) begin
                    push = 1; e = mk(m_cnt, 1, 0); m_mode = 0; m_cnt = 0;
                end else if (m_cnt == MAX_BEATS-1 || free == 1) begin
                    push = 1; e = mk(m_cnt, 1, 1);
                    sp = (m_cnt == MAX_BEATS-1); so = (free == 1);
                    m_mode = 2; m_cnt = 0;
                end else begin
                    push = 1; e = mk(m_cnt, 0, 0); m_cnt++;
                end
            end else if (done) begin
                m_mode = 0;
            end
        end
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
        m_ovf   = so ? 1'b1 : (i_err_clr ? 1'b0 : m_ovf);
        m_proto = sp ? 1'b1 : (i_err_clr ? 1'b0 : m_proto);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            ent_t h;
            h = (q.size() > 0) ? q[0] : '0;
            chk("vld",   o_vld,       q.size() > 0);
            chk("fill",  o_fill,      q.size());
            chk("ovf",   o_err_ovf,   m_ovf);
            chk("proto", o_err_proto, m_proto);
            chk("wdat",  o_wdat,      h.wdat);
            chk("sub",   o_sub,       h.sub);
            chk("idx",   o_beat_idx,  h.idx);
            chk("last",  o_last,      h.last);
            chk("trunc", o_trunc,     h.trunc);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [35:0] rw();
        return 36'({$urandom, $urandom});
    endfunction

    // Entered and left at posedge+1.
    task automatic tick(input logic [1:0] ct, input logic en, input logic rdy,
                        input logic clr, input logic [35:0] wd);
        d_ct = ct; d_en = en; d_wdat = wd; d_sub = 7'($urandom);
        i_rdy = rdy; i_err_clr = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int r, rdy_pct, done_pct;
        rst = 1'b1; d_ct = CT_IDLE; d_en = 0; d_wdat = '0; d_sub = '0;
        i_rdy = 0; i_err_clr = 0;
        model_reset();
        #12;
        chk("rst_vld",   o_vld, 0);
        chk("rst_fill",  o_fill, 0);
        chk("rst_ovf",   o_err_ovf, 0);
        chk("rst_proto", o_err_proto, 0);
        chk("rst_wdat",  o_wdat, 0);
        @(posedge clk); #1;
        rst = 1'b0; chk_en = 1'b1;

        // VALID, VALID, DONE with downstream always ready
        tick(CT_VALID, 1, 1, 0, rw());
        chk("t1_vld0", o_vld, 1); chk("t1_idx0", o_beat_idx, 0); chk("t1_last0", o_last, 0);
        tick(CT_VALID, 1, 1, 0, rw());
        chk("t1_vld1", o_vld, 1); chk("t1_idx1", o_beat_idx, 1); chk("t1_last1", o_last, 0);
        tick(CT_DONE, 1, 1, 0, rw());
        chk("t1_idx2", o_beat_idx, 2); chk("t1_last2", o_last, 1); chk("t1_trunc2", o_trunc, 0);
        tick(CT_IDLE, 0, 1, 0, rw());
        chk("t1_empty", o_vld, 0);

        // Lone DONE
        tick(CT_DONE, 1, 0, 0, 36'h123456789);
        chk("t2_vld", o_vld, 1); chk("t2_wdat", o_wdat, 36'h123456789);
        chk("t2_idx", o_beat_idx, 0); chk("t2_last", o_last, 1);
        tick(CT_IDLE, 0, 1, 0, rw());

        // Overflow: 10 VALID + DONE into a stalled FIFO
        for (int i = 0; i < 10; i++) tick(CT_VALID, 1, 0, 0, rw());
        tick(CT_DONE, 1, 0, 0, rw());
        chk("t3_fill", o_fill, 8); chk("t3_ovf", o_err_ovf, 1); chk("t3_head", o_beat_idx, 0);
        for (int i = 0; i < 7; i++) tick(CT_IDLE, 0, 1, 0, rw());
        chk("t3_idx7", o_beat_idx, 7); chk("t3_last7", o_last, 1); chk("t3_trunc7", o_trunc, 1);
        tick(CT_IDLE, 0, 1, 0, rw());
        chk("t3_drained", o_fill, 0);
        tick(CT_VALID, 1, 1, 0, rw());
        chk("t3_new_idx", o_beat_idx, 0); chk("t3_new_vld", o_vld, 1);
        tick(CT_DONE, 1, 1, 0, rw());
        chk("t3_new_last", o_last, 1); chk("t3_new_idx1", o_beat_idx, 1);
        tick(CT_IDLE, 0, 1, 1, rw());
        chk("t3_clr", o_err_ovf, 0);

        // Over-length: 20 VALID + DONE
        for (int i = 0; i < 20; i++) begin
            tick(CT_VALID, 1, 1, 0, rw());
            if (i == 15) begin
                chk("t4_idx15", o_beat_idx, 15); chk("t4_last15", o_last, 1);
                chk("t4_trunc15", o_trunc, 1);
            end
            if (i == 16) begin
                chk("t4_drop", o_vld, 0); chk("t4_proto", o_err_proto, 1);
            end
        end
        tick(CT_DONE, 1, 1, 0, rw());
        chk("t4_done_dropped", o_vld, 0);
        tick(CT_DONE, 1, 1, 0, rw());
        chk("t4_idle_idx", o_beat_idx, 0); chk("t4_idle_last", o_last, 1);
        tick(CT_IDLE, 0, 1, 1, rw());

        // clk_en, illegal cycle type, clear priority
        tick(CT_VALID, 0, 1, 0, rw());
        chk("t5_noen", o_vld, 0);
        tick(CT_BAD, 1, 1, 0, rw());
        chk("t5_bad_proto", o_err_proto, 1); chk("t5_bad_vld", o_vld, 0);
        tick(CT_IDLE, 0, 1, 1, rw());
        chk("t5_clr_proto", o_err_proto, 0); chk("t5_clr_ovf", o_err_ovf, 0);
        tick(CT_BAD, 1, 1, 1, rw());
        chk("t5_set_wins", o_err_proto, 1);
        tick(CT_IDLE, 0, 1, 1, rw());

        // Asynchronous reset mid-transaction
        for (int i = 0; i < 4; i++) tick(CT_VALID, 1, 0, 0, rw());
        chk("t6_fill4", o_fill, 4);
        d_en = 0; d_ct = CT_IDLE;
        #2 rst = 1'b1;
        #1;
        chk("t6_async_vld", o_vld, 0); chk("t6_async_fill", o_fill, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        tick(CT_DONE, 1, 0, 0, rw());
        chk("t6_vld", o_vld, 1); chk("t6_idx", o_beat_idx, 0);
        chk("t6_last", o_last, 1); chk("t6_fill", o_fill, 1);
        tick(CT_IDLE, 0, 1, 0, rw());

        // Randomized traffic, alternating backpressure and framing density
        for (int i = 0; i < 4000; i++) begin
            rdy_pct  = ((i / 400) % 2 == 0) ? 35 : 90;
            done_pct = ((i / 800) % 2 == 0) ? 18 : 3;
            r = $urandom_range(99);
            tick((r < 3) ? CT_BAD : (r < 3 + done_pct) ? CT_DONE : (r < 92) ? CT_VALID : CT_IDLE,
                 ($urandom_range(99) < 90), ($urandom_range(99) < rdy_pct),
                 ($urandom_range(99) < 3), rw());
        end
        for (int i = 0; i < 12; i++) tick(CT_IDLE, 0, 1, 0, rw());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
